// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the burst clock divider.
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned BURST_W_DEF = 5;
  localparam int unsigned NUM_PH_DEF  = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_burst_if.sv
// Control and status bundle between a burst requester and clk_div_burst.
interface clk_div_burst_if #(
  parameter int unsigned CNT_W   = clk_div_pkg::CNT_W_DEF,
  parameter int unsigned BURST_W = clk_div_pkg::BURST_W_DEF,
  parameter int unsigned NUM_PH  = clk_div_pkg::NUM_PH_DEF
);

  logic               en;
  logic               start;
  logic               stop;
  logic [CNT_W-1:0]   div_ratio;
  logic [BURST_W-1:0] num_cycles;
  logic [NUM_PH-1:0]  clk_cmp;
  logic               busy;
  logic               done;

  modport master (
    output en, start, stop, div_ratio, num_cycles,
    input  clk_cmp, busy, done
  );

  modport slave (
    input  en, start, stop, div_ratio, num_cycles,
    output clk_cmp, busy, done
  );

endinterface

// File: rtl/clk_phase_dly.sv
// Registered delay line producing phase-shifted copies of the comparator clock.
module clk_phase_dly #(
  parameter int unsigned NUM_PH = clk_div_pkg::NUM_PH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ph0,
  output logic [NUM_PH-1:0] ph
);

  if (NUM_PH > 1) begin : g_dly
    logic [NUM_PH-2:0] dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q <= '0;
      end else if (clr) begin
        dly_q <= '0;
      end else begin
        dly_q[0] <= ph0;
        for (int k = 1; k < int'(NUM_PH) - 1; k++) begin
          dly_q[k] <= dly_q[k-1];
        end
      end
    end

    assign ph = {dly_q, ph0};
  end else begin : g_none
    assign ph = ph0;
  end

endmodule

// File: rtl/clk_div_burst.sv
// Burst clock generator: emits N periods of a 2H-cycle clock (or free-runs until
// stop), followed by a drain window and a one-cycle done pulse.
module clk_div_burst #(
  parameter int unsigned CNT_W   = clk_div_pkg::CNT_W_DEF,
  parameter int unsigned BURST_W = clk_div_pkg::BURST_W_DEF,
  parameter int unsigned NUM_PH  = clk_div_pkg::NUM_PH_DEF
) (
  input logic            clk,
  input logic            rst_n,
  clk_div_burst_if.slave bus
);
  import clk_div_pkg::*;

  // Drain length is up to H + NUM_PH - 1, so a few bits of headroom over CNT_W.
  localparam int unsigned DCNT_W = CNT_W + 4;

  state_e             state_q, state_d;
  logic               clk0_q, clk0_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [BURST_W-1:0] n_q, n_d;
  logic               stop_pend_q, stop_pend_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   h_eff;
  logic               last_fall;

  assign h_eff = (bus.div_ratio == '0) ? CNT_W'(1) : bus.div_ratio;

  // Fixed bursts end on the Nth fall; free-run ends on the first fall after stop.
  assign last_fall = (n_q != '0) ? (bcnt_q == n_q - BURST_W'(1))
                                 : (stop_pend_q | bus.stop);

  always_comb begin
    state_d     = state_q;
    clk0_d      = clk0_q;
    hcnt_d      = hcnt_q;
    bcnt_d      = bcnt_q;
    dcnt_d      = dcnt_q;
    h_d         = h_q;
    n_d         = n_q;
    stop_pend_d = stop_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (!bus.en) begin
      state_d     = StIdle;
      clk0_d      = 1'b0;
      hcnt_d      = '0;
      bcnt_d      = '0;
      dcnt_d      = '0;
      stop_pend_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A start coinciding with the done pulse is dropped.
          if (bus.start && !done_q) begin
            h_d         = h_eff;
            n_d         = bus.num_cycles;
            hcnt_d      = h_eff - CNT_W'(1);
            bcnt_d      = '0;
            stop_pend_d = 1'b0;
            clk0_d      = 1'b1;
            busy_d      = 1'b1;
            state_d     = StRun;
          end
        end
        StRun: begin
          if (bus.stop && (n_q == '0)) begin
            stop_pend_d = 1'b1;
          end
          if (hcnt_q == '0) begin
            hcnt_d = h_q - CNT_W'(1);
            clk0_d = ~clk0_q;
            if (clk0_q) begin
              if (last_fall) begin
                state_d = StDrain;
                dcnt_d  = DCNT_W'(h_q) + DCNT_W'(NUM_PH) - DCNT_W'(2);
              end else if (n_q != '0) begin
                bcnt_d = bcnt_q + BURST_W'(1);
              end
            end
          end else begin
            hcnt_d = hcnt_q - CNT_W'(1);
          end
        end
        StDrain: begin
          if (dcnt_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            dcnt_d = dcnt_q - DCNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          clk0_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clk0_q      <= 1'b0;
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      dcnt_q      <= '0;
      h_q         <= '0;
      n_q         <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk0_q      <= clk0_d;
      hcnt_q      <= hcnt_d;
      bcnt_q      <= bcnt_d;
      dcnt_q      <= dcnt_d;
      h_q         <= h_d;
      n_q         <= n_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  clk_phase_dly #(
    .NUM_PH(NUM_PH)
  ) u_phase_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!bus.en),
    .ph0  (clk0_q),
    .ph   (bus.clk_cmp)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_clk_div_burst.sv
// Scoreboard bench for clk_div_burst: expected per-cycle outputs are queued when a
// burst is launched and compared cycle by cycle against the DUT.
module tb_clk_div_burst;
  import clk_div_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BURST_W = 5;
  localparam int unsigned NUM_PH  = 2;

  typedef struct packed {
    logic [NUM_PH-1:0] cmp;
    logic              busy;
    logic              done;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clk_div_burst_if #(.CNT_W(CNT_W), .BURST_W(BURST_W), .NUM_PH(NUM_PH)) bus ();

  clk_div_burst #(.CNT_W(CNT_W), .BURST_W(BURST_W), .NUM_PH(NUM_PH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  // Cycle (relative to the start cycle 0) of the final falling edge of clk_cmp[0].
  function automatic int fall_cyc(int h, int n, int s);
    int hh, f;
    hh = (h == 0) ? 1 : h;
    if (n > 0) begin
      f = (2 * n - 1) * hh + 1;
    end else begin
      f = hh + 1;
      while (f < s + 1) f = f + 2 * hh;
    end
    return f;
  endfunction

  function automatic int done_cyc(int h, int n, int s);
    int hh;
    hh = (h == 0) ? 1 : h;
    return fall_cyc(h, n, s) + hh + int'(NUM_PH) - 1;
  endfunction

  function automatic obs_t exp_at(int h, int n, int s, int c);
    obs_t o;
    int   hh, f, d, ck;
    hh = (h == 0) ? 1 : h;
    f  = fall_cyc(h, n, s);
    d  = done_cyc(h, n, s);
    o  = '0;
    for (int k = 0; k < int'(NUM_PH); k++) begin
      ck = c - k;
      if (ck >= 1 && ck < f) o.cmp[k] = (((ck - 1) / hh) % 2) == 0;
    end
    o.busy = (c >= 1) && (c < d);
    o.done = (c == d);
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.cmp  = bus.clk_cmp;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(int h, int n);
    bus.div_ratio  = CNT_W'(h);
    bus.num_cycles = BURST_W'(n);
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    set_cfg(2, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_outputs i=%0d got %b want %b", i, o, obs_t'('0));
      end
      checks++;
      if (dut.state_q !== StIdle) begin
        errors++;
        $display("FAIL reset_state got %0d want %0d", dut.state_q, StIdle);
      end
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = observe();
      checks++;
      if (o !== '0) begin
        errors++;
        $display("FAIL reset_idle i=%0d got %b want %b", i, o, obs_t'('0));
      end
      next_cycle();
    end
  endtask

  task automatic test_basic();
    obs_t e, o;
    int   d;
    set_cfg(2, 3);
    d = done_cyc(2, 3, -1);
    for (int c = 0; c <= d + 1; c++) exp_q.push_back(exp_at(2, 3, -1, c));
    for (int c = 0; c <= d + 1; c++) begin
      bus.start = (c == 0);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic c=%0d got %b want %b", c, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_div_zero();
    obs_t e, o;
    int   d;
    set_cfg(0, 1);
    d = done_cyc(0, 1, -1);
    for (int c = 0; c <= d + 1; c++) exp_q.push_back(exp_at(0, 1, -1, c));
    for (int c = 0; c <= d + 1; c++) begin
      bus.start = (c == 0);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL div_zero c=%0d got %b want %b", c, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_free_run_stop();
    obs_t e, o;
    int   d;
    set_cfg(3, 0);
    d = done_cyc(3, 0, 8);
    for (int c = 0; c <= d + 1; c++) exp_q.push_back(exp_at(3, 0, 8, c));
    for (int c = 0; c <= d + 1; c++) begin
      bus.start = (c == 0);
      // Stop in IDLE (cycle 0) and in DRAIN (cycle 11) must be ignored.
      bus.stop  = (c == 0) || (c == 8) || (c == 11);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL free_run_stop c=%0d got %b want %b", c, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_en_abort();
    obs_t e, o;
    int   d, last;
    set_cfg(2, 3);
    d    = done_cyc(2, 3, -1);
    last = 8 + d + 1;
    for (int g = 0; g <= last; g++) begin
      if (g <= 5)      exp_q.push_back(exp_at(2, 3, -1, g));
      else if (g < 8)  exp_q.push_back('0);
      else             exp_q.push_back(exp_at(2, 3, -1, g - 8));
    end
    for (int g = 0; g <= last; g++) begin
      bus.en    = !(g == 5 || g == 6);
      bus.start = (g == 0) || (g == 8);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL en_abort g=%0d got %b want %b", g, o, e);
      end
      next_cycle();
    end
    bus.en    = 1'b1;
    bus.start = 1'b0;
  endtask

  task automatic test_disturb();
    obs_t e, o;
    int   d;
    set_cfg(2, 3);
    d = done_cyc(2, 3, -1);
    for (int c = 0; c <= d + 1; c++) exp_q.push_back(exp_at(2, 3, -1, c));
    for (int c = 0; c <= d + 1; c++) begin
      bus.start = (c == 0) || (c == 3) || (c == 9) || (c == 12);
      bus.stop  = (c == 4);
      if (c >= 2) set_cfg(7, 1);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL disturb c=%0d got %b want %b", c, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_start_at_done();
    obs_t e, o;
    int   d, last;
    set_cfg(1, 1);
    d    = done_cyc(1, 1, -1);
    last = 2 * d + 2;
    for (int g = 0; g <= last; g++) begin
      if (g <= d) exp_q.push_back(exp_at(1, 1, -1, g));
      else        exp_q.push_back(exp_at(1, 1, -1, g - d - 1));
    end
    for (int g = 0; g <= last; g++) begin
      // Start in DRAIN and in the done cycle are lost; the one after done is taken.
      bus.start = (g == 0) || (g == 3) || (g == d) || (g == d + 1);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_at_done g=%0d got %b want %b", g, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_max_burst();
    obs_t e, o;
    int   d;
    set_cfg(1, 31);
    d = done_cyc(1, 31, -1);
    for (int c = 0; c <= d + 1; c++) exp_q.push_back(exp_at(1, 31, -1, c));
    for (int c = 0; c <= d + 1; c++) begin
      bus.start = (c == 0);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL max_burst c=%0d got %b want %b", c, o, e);
      end
      next_cycle();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    set_cfg(2, 3);
    for (int c = 0; c <= 6; c++) exp_q.push_back(exp_at(2, 3, -1, c));
    for (int c = 0; c <= 6; c++) begin
      bus.start = (c == 0);
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_rst_pre c=%0d got %b want %b", c, o, e);
      end
      if (c < 6) next_cycle();
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    o = observe();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL async_rst_outputs got %b want %b", o, obs_t'('0));
    end
    checks++;
    if (dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL async_rst_state got %0d want %0d", dut.state_q, StIdle);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 12; i++) exp_q.push_back('0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      o = observe();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_rst_post i=%0d got %b want %b", i, o, e);
      end
      next_cycle();
    end
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    set_cfg(0, 0);
    test_reset();
    test_basic();
    test_div_zero();
    test_free_run_stop();
    test_en_abort();
    test_disturb();
    test_start_at_done();
    test_max_burst();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/clk_div_burst.md
CLK_DIV_BURST -- requirements
Module: clk_div_burst

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the half-period divider setting.
REQ-002 SHALL have parameter BURST_W, default 5: width of the burst-length setting.
REQ-003 SHALL have parameter NUM_PH, default 2, legal range 1..8: number of comparator clock phases.
REQ-004 SHALL have port clk, input, 1: single clock; all logic uses its rising edge only.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1: synchronous enable; low aborts any activity.
REQ-007 SHALL have port start, input, 1: one-cycle request that begins a burst.
REQ-008 SHALL have port stop, input, 1: graceful end request, used in free-run mode.
REQ-009 SHALL have port div_ratio, input, CNT_W: half-period H in clk cycles; 0 is treated as 1.
REQ-010 SHALL have port num_cycles, input, BURST_W: burst length N in full periods; 0 selects free-run.
REQ-011 SHALL have port clk_cmp, output, NUM_PH: comparator clocks; bit k is bit 0 delayed k clk cycles.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at burst completion.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DRAIN, with IDLE as the reset state.
REQ-015 SHALL accept start only when en=1 and state=IDLE, latching div_ratio and num_cycles into shadow registers.
REQ-016 SHALL ignore start in any state other than IDLE.
REQ-017 SHALL ignore changes to div_ratio and num_cycles while busy=1.
REQ-018 SHALL, for start accepted at cycle T, drive clk_cmp[0] high over cycles T+1..T+H and low over T+H+1..T+2H, repeating with period 2H and 50% duty.
REQ-019 SHALL make all outputs registered.
REQ-020 SHALL implement clk_cmp[k] as a k-stage registered delay of clk_cmp[0], giving a phase offset of k clk cycles.
REQ-021 SHALL, for N>0, count falling edges of clk_cmp[0]; on the Nth falling edge (cycle F = T+(2N-1)H+1) it SHALL enter DRAIN and hold clk_cmp[0] low.
REQ-022 SHALL, in DRAIN, wait H+NUM_PH-1 cycles, then assert done for one cycle, deassert busy in that same cycle and return to IDLE. Done therefore occurs at T+2NH+NUM_PH.
REQ-023 SHALL, for N=0, run until stop=1 is sampled in RUN, then complete the current period and enter DRAIN at the next falling edge of clk_cmp[0]; the drain timing is the same as REQ-022.
REQ-024 SHALL treat stop as a no-op in IDLE, in DRAIN, and when N>0.
REQ-025 SHALL, on en=0 in any state, force clk_cmp=0, the delay line=0, busy=0 and the state to IDLE on the next edge, with no done pulse.
REQ-026 SHALL accept a start sampled in the same cycle as done only on the following cycle; such a start is lost, and the bench checks this.
REQ-027 SHALL size the burst counter at BURST_W bits; N=2^BURST_W-1 SHALL complete without wrap.
REQ-028 SHALL size the half-period counter at CNT_W bits; it reloads to H-1 at each toggle and never wraps.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force the state to IDLE, clk_cmp=0, the delay line=0, busy=0, done=0, and all counters and shadow registers to 0.
REQ-030 SHALL begin normal behaviour on the first rising clk edge after rst_n deasserts; asserting rst_n mid-burst SHALL abort the burst with no done pulse.

Structure
REQ-031 SHALL use a shared package clk_div_pkg holding the FSM state enum and the default CNT_W, BURST_W and NUM_PH constants.
REQ-032 SHALL place the phase delay line in sub-module clk_phase_dly, parameterised by NUM_PH, with clock, reset, a clear input and clk_cmp[0] as its input.

Verification
REQ-033 Bench SHALL check: H=2, N=3, NUM_PH=2, start at cycle 0 -> clk_cmp[0] high at cycles 1-2, 5-6 and 9-10; clk_cmp[1] high at 2-3, 6-7 and 10-11; done at cycle 14 only.
REQ-034 Bench SHALL check: div_ratio=0, N=1 -> clk_cmp[0] high at cycle 1, low at cycle 2, done at cycle 4 (NUM_PH=2).
REQ-035 Bench SHALL check: N=0, H=3, stop at cycle 8 -> the period completes, clk_cmp[0] falls at cycle 10 and stays low, done at cycle 14.
REQ-036 Bench SHALL check: en dropped at cycle 5 of a running burst -> all outputs are 0 at cycle 6, there is no done pulse, and a new start at cycle 8 runs normally.
REQ-037 Bench SHALL check: start re-pulsed while busy, and div_ratio changed mid-burst -> the waveform is identical to the undisturbed case.
REQ-038 Bench SHALL check: rst_n pulsed low asynchronously mid-cycle during RUN -> outputs are 0 immediately, the state is IDLE, and there is no done pulse.
